// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, default
// vector addresses and opcode-length decode.
package fetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_RESET_VEC = 2'd0,
    ST_FETCH     = 2'd1,
    ST_FETCH_IMM = 2'd2,
    ST_HALTED    = 2'd3
  } fetch_state_e;

  // Memory locations holding the start PC after reset and the ISR entry PC
  localparam logic [7:0] RST_VEC_ADDR_DEF = 8'h00;
  localparam logic [7:0] INT_VEC_ADDR_DEF = 8'h01;

  // LDM/LDD/STD (opcode class 0xC_) carry a second byte
  function automatic logic is_two_byte(input logic [7:0] opcode);
    return (opcode[7:4] == 4'hC);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the shared memory address,
// loads reset/interrupt vectors and assembles 1- and 2-byte instructions
// into the IF/ID register. Handles stall, flush, HLT and interrupts.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W       = 8,
  parameter int                 DATA_W       = 8,
  parameter logic [ADDR_W-1:0]  RST_VEC_ADDR = RST_VEC_ADDR_DEF,
  parameter logic [ADDR_W-1:0]  INT_VEC_ADDR = INT_VEC_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  input  logic              hlt_req,
  input  logic              int_req,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_imm,
  output logic [ADDR_W-1:0] if_id_pc_next,
  output logic              if_id_valid,
  output logic              int_ack,
  output logic [ADDR_W-1:0] int_ret_pc,
  output logic              halted
);

  fetch_state_e      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] opcode_hold_reg;
  logic              int_pending_reg;
  logic [DATA_W-1:0] if_id_instr_reg;
  logic [DATA_W-1:0] if_id_imm_reg;
  logic [ADDR_W-1:0] if_id_pc_next_reg;
  logic              if_id_valid_reg;
  logic              int_ack_reg;
  logic [ADDR_W-1:0] int_ret_pc_reg;
  logic              halted_reg;

  logic              flush_take;
  logic              halt_take;
  logic              int_take;
  logic [ADDR_W-1:0] pc_plus1;

  // Decide which action wins this edge (flush > stall > hlt > interrupt)
  // and steer the memory address to the vector while servicing.
  always_comb begin
    flush_take = flush && ((state_reg == ST_FETCH) || (state_reg == ST_FETCH_IMM));
    halt_take  = !flush_take && !stall && hlt_req &&
                 ((state_reg == ST_FETCH) || (state_reg == ST_FETCH_IMM));
    int_take   = !flush_take && !stall && !halt_take && int_pending_reg &&
                 ((state_reg == ST_FETCH) || (state_reg == ST_HALTED));
    pc_plus1   = pc_reg + ADDR_W'(1);
    if (state_reg == ST_RESET_VEC) begin
      mem_addr = RST_VEC_ADDR;
    end else if (int_take) begin
      mem_addr = INT_VEC_ADDR;
    end else begin
      mem_addr = pc_reg;
    end
  end

  // Fetch FSM with PC, IF/ID and interrupt bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_RESET_VEC;
      pc_reg            <= '0;
      opcode_hold_reg   <= '0;
      int_pending_reg   <= 1'b0;
      if_id_instr_reg   <= '0;
      if_id_imm_reg     <= '0;
      if_id_pc_next_reg <= '0;
      if_id_valid_reg   <= 1'b0;
      int_ack_reg       <= 1'b0;
      int_ret_pc_reg    <= '0;
      halted_reg        <= 1'b0;
    end else begin
      // The ack is a strict single-cycle pulse, even across a stall
      int_ack_reg     <= 1'b0;
      int_pending_reg <= (int_pending_reg | int_req) & ~int_take;
      if (state_reg == ST_RESET_VEC) begin
        pc_reg          <= ADDR_W'(mem_data);
        if_id_valid_reg <= 1'b0;
        state_reg       <= ST_FETCH;
      end else if (flush_take) begin
        pc_reg          <= flush_target;
        if_id_valid_reg <= 1'b0;
        state_reg       <= ST_FETCH;
      end else if (stall) begin
        // hold everything
      end else if (halt_take) begin
        if_id_valid_reg <= 1'b0;
        halted_reg      <= 1'b1;
        state_reg       <= ST_HALTED;
      end else if (int_take) begin
        int_ret_pc_reg  <= pc_reg;
        pc_reg          <= ADDR_W'(mem_data);
        int_ack_reg     <= 1'b1;
        if_id_valid_reg <= 1'b0;
        halted_reg      <= 1'b0;
        state_reg       <= ST_FETCH;
      end else begin
        case (state_reg)
          ST_FETCH: begin
            pc_reg <= pc_plus1;
            if (is_two_byte(mem_data)) begin
              opcode_hold_reg <= mem_data;
              if_id_valid_reg <= 1'b0;
              state_reg       <= ST_FETCH_IMM;
            end else begin
              if_id_instr_reg   <= mem_data;
              if_id_imm_reg     <= '0;
              if_id_valid_reg   <= 1'b1;
              if_id_pc_next_reg <= pc_plus1;
            end
          end
          ST_FETCH_IMM: begin
            if_id_instr_reg   <= opcode_hold_reg;
            if_id_imm_reg     <= mem_data;
            if_id_valid_reg   <= 1'b1;
            pc_reg            <= pc_plus1;
            if_id_pc_next_reg <= pc_plus1;
            state_reg         <= ST_FETCH;
          end
          default: begin
            // halted: wait for an interrupt
          end
        endcase
      end
    end
  end

  assign pc            = pc_reg;
  assign if_id_instr   = if_id_instr_reg;
  assign if_id_imm     = if_id_imm_reg;
  assign if_id_pc_next = if_id_pc_next_reg;
  assign if_id_valid   = if_id_valid_reg;
  assign int_ack       = int_ack_reg;
  assign int_ret_pc    = int_ret_pc_reg;
  assign halted        = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized stall/flush/halt/interrupt/reset traffic checked every cycle
// against a behavioural model of the fetch stage.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       stall, flush, hlt_req, int_req;
  logic [7:0] flush_target;
  logic [7:0] pc, if_id_instr, if_id_imm, if_id_pc_next, int_ret_pc;
  logic       if_id_valid, int_ack, halted;

  logic [7:0] mem [256];
  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .stall(stall), .flush(flush), .flush_target(flush_target),
    .hlt_req(hlt_req), .int_req(int_req), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_imm(if_id_imm),
    .if_id_pc_next(if_id_pc_next), .if_id_valid(if_id_valid),
    .int_ack(int_ack), .int_ret_pc(int_ret_pc), .halted(halted)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // model: phase 0 = loading reset vector, 1 = at instruction boundary,
  // 2 = waiting for immediate byte, 3 = halted
  int         ph = 0;
  logic [7:0] m_pc = 0, m_hold = 0, m_instr = 0, m_imm = 0, m_pcn = 0, m_ret = 0;
  logic       m_valid = 0, m_ack = 0, m_pend = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: predict, check the address, clock, then compare outputs
  task automatic step();
    int         nph;
    logic [7:0] npc, nhold, ninstr, nimm, npcn, nret, b, ea;
    logic       nvalid, nack, npend, deliver;
    @(negedge clk);
    nph = ph; npc = m_pc; nhold = m_hold; ninstr = m_instr; nimm = m_imm;
    npcn = m_pcn; nret = m_ret; nvalid = m_valid; nack = m_ack; npend = m_pend;
    deliver = 1'b0;
    ea = (ph == 0) ? 8'h00 : m_pc;
    if (rst) begin
      nph = 0; npc = 0; nhold = 0; ninstr = 0; nimm = 0; npcn = 0; nret = 0;
      nvalid = 0; nack = 0; npend = 0;
    end else begin
      nack  = 1'b0;
      npend = m_pend | int_req;
      if (ph == 0) begin
        npc = mem[8'h00]; nvalid = 0; nph = 1;
      end else if (flush && ph != 3) begin
        npc = flush_target; nvalid = 0; nph = 1;
      end else if (stall) begin
        // frozen
      end else if (hlt_req && (ph == 1 || ph == 2)) begin
        nph = 3; nvalid = 0;
      end else if (m_pend && (ph == 1 || ph == 3)) begin
        ea = 8'h01; nret = m_pc; npc = mem[8'h01]; nack = 1; npend = 0;
        nvalid = 0; nph = 1;
      end else if (ph == 1) begin
        b = mem[m_pc];
        npc = m_pc + 8'd1;
        if (b[7:4] == 4'hC) begin
          nhold = b; nvalid = 0; nph = 2;
        end else begin
          ninstr = b; nimm = 0; nvalid = 1; npcn = npc; deliver = 1;
        end
      end else if (ph == 2) begin
        ninstr = m_hold; nimm = mem[m_pc]; npc = m_pc + 8'd1; npcn = npc;
        nvalid = 1; nph = 1; deliver = 1;
      end
    end
    if (!rst) check("mem_addr", mem_addr, ea);
    @(posedge clk);
    #1;
    ph = nph; m_pc = npc; m_hold = nhold; m_instr = ninstr; m_imm = nimm;
    m_pcn = npcn; m_ret = nret; m_valid = nvalid; m_ack = nack; m_pend = npend;
    check("pc", pc, m_pc);
    check("if_id_valid", if_id_valid, m_valid);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_imm", if_id_imm, m_imm);
    check("if_id_pc_next", if_id_pc_next, m_pcn);
    check("int_ack", int_ack, m_ack);
    check("int_ret_pc", int_ret_pc, m_ret);
    check("halted", halted, ph == 3);
    if (deliver)
      $display("[%0t] deliver instr=%02h imm=%02h pc_next=%02h", $time, m_instr, m_imm, m_pcn);
    if (m_ack)
      $display("[%0t] interrupt taken ret=%02h isr=%02h", $time, m_ret, m_pc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
    mem[8'h00] = 8'h02; mem[8'h01] = 8'h6E; mem[8'h02] = 8'h21;
    mem[8'h03] = 8'hC1; mem[8'h04] = 8'h5A; mem[8'h40] = 8'h77;
    rst = 1; stall = 0; flush = 0; hlt_req = 0; int_req = 0; flush_target = 0;
    @(posedge clk); #1;

    // reset
    for (int i = 0; i < 3; i++) step();
    check("rst_pc", pc, 8'h00);
    check("rst_valid", if_id_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_ack", int_ack, 1'b0);

    // reset vector and first one-byte instruction
    rst = 0; step();
    check("rv_pc", pc, 8'h02);
    check("rv_valid", if_id_valid, 1'b0);
    step();
    check("i1_instr", if_id_instr, 8'h21);
    check("i1_valid", if_id_valid, 1'b1);
    check("i1_pc", pc, 8'h03);
    check("i1_pcn", if_id_pc_next, 8'h03);

    // two-byte instruction, interrupt pulsed during immediate fetch
    step();
    check("tb_gap_valid", if_id_valid, 1'b0);
    check("tb_gap_pc", pc, 8'h04);
    int_req = 1; step(); int_req = 0;
    check("tb_instr", if_id_instr, 8'hC1);
    check("tb_imm", if_id_imm, 8'h5A);
    check("tb_pc", pc, 8'h05);
    check("tb_ack_not_yet", int_ack, 1'b0);
    step();
    check("int_ack", int_ack, 1'b1);
    check("int_ret", int_ret_pc, 8'h05);
    check("int_pc", pc, 8'h6E);
    step();
    check("int_ack_once", int_ack, 1'b0);
    check("isr_instr", if_id_instr, 8'h01);
    check("isr_pc", pc, 8'h6F);

    // stall, then stall+flush
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc", pc, 8'h6F);
      check("stall_instr", if_id_instr, 8'h01);
      check("stall_valid", if_id_valid, 1'b1);
    end
    flush = 1; flush_target = 8'h40; step();
    check("flush_pc", pc, 8'h40);
    check("flush_valid", if_id_valid, 1'b0);
    stall = 0; flush = 0; step();
    check("flush_instr", if_id_instr, 8'h77);
    check("flush_deliv_valid", if_id_valid, 1'b1);

    // halt, flush ignored, interrupt wakes
    flush = 1; flush_target = 8'h10; step(); flush = 0;
    hlt_req = 1; step(); hlt_req = 0;
    check("hlt_halted", halted, 1'b1);
    for (int i = 0; i < 6; i++) begin
      flush = i[0]; flush_target = 8'h80;
      step();
      check("hlt_pc_hold", pc, 8'h10);
      check("hlt_stay", halted, 1'b1);
    end
    flush = 0; int_req = 1; step(); int_req = 0; step();
    check("wake_ack", int_ack, 1'b1);
    check("wake_pc", pc, 8'h6E);
    check("wake_halted", halted, 1'b0);
    check("wake_ret", int_ret_pc, 8'h10);

    // PC wrap with two-byte opcode at 0xFF
    mem[8'hFF] = 8'hC2; mem[8'h00] = 8'h33;
    flush = 1; flush_target = 8'hFF; step(); flush = 0;
    step();
    check("wrap_gap_pc", pc, 8'h00);
    step();
    check("wrap_instr", if_id_instr, 8'hC2);
    check("wrap_imm", if_id_imm, 8'h33);
    check("wrap_pc", pc, 8'h01);

    // reset in the middle of an immediate fetch, with an interrupt request
    flush = 1; step(); flush = 0; step();
    rst = 1; int_req = 1; step(); int_req = 0;
    check("mid_rst_pc", pc, 8'h00);
    check("mid_rst_valid", if_id_valid, 1'b0);
    check("mid_rst_instr", if_id_instr, 8'h00);
    check("mid_rst_ret", int_ret_pc, 8'h00);
    rst = 0; step();
    check("reload_pc", pc, 8'h33);
    step();
    check("no_stale_int", int_ack, 1'b0);

    // randomized traffic
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? {4'hC, 4'($urandom)} : 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      stall        = ($urandom_range(0, 99) < 15);
      flush        = ($urandom_range(0, 99) < 6);
      hlt_req      = ($urandom_range(0, 99) < 4);
      int_req      = ($urandom_range(0, 99) < 4);
      flush_target = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
